// File: rtl/ec_fp_op_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ec_fp_op_arbiter_pkg
// Shared definitions for the Fp operation arbiter:
//   MAX_CLIENTS / PTR_BITS : upper bound on clients and width of the RR pointer
//   rr_pick_t              : result of a round-robin search (found flag + index)
//   clog2_min1()           : ceil(log2(n)), never less than 1
//   rr_find_first()        : first set request at or after a pointer, with wrap
// ---------------------------------------------------------------------------
package ec_fp_op_arbiter_pkg;

    localparam int MAX_CLIENTS = 8;
    localparam int PTR_BITS    = 3;

    typedef struct packed {
        logic                found;
        logic [PTR_BITS-1:0] idx;
    } rr_pick_t;

    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Scan n requesters starting at ptr, wrapping back to 0. ptr must be < n.
    function automatic rr_pick_t rr_find_first(input logic [MAX_CLIENTS-1:0] req,
                                               input int ptr, input int n);
        rr_pick_t pick;
        int       j;
        pick = '0;
        for (int i = 0; i < MAX_CLIENTS; i++) begin
            if (i < n) begin
                j = ptr + i;
                if (j >= n) j = j - n;
                if (!pick.found && req[j[PTR_BITS-1:0]]) begin
                    pick.found = 1'b1;
                    pick.idx   = j[PTR_BITS-1:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ec_fp_op_arbiter_if.sv
// ---------------------------------------------------------------------------
// ec_fp_op_arbiter_if
// Single-beat valid/ready stream used on every side of the arbiter.
//   val/rdy   : handshake
//   sop/eop   : packet framing (always 1 for single-beat Fp operations)
//   err, mod  : side-band flags carried with the data
//   dat, ctl  : payload and control/tag word
// master drives the payload and samples rdy; slave is the reverse.
// ---------------------------------------------------------------------------
interface ec_fp_op_arbiter_if #(
    parameter int DAT_BITS = 8,
    parameter int CTL_BITS = 16,
    parameter int MOD_BITS = 1
);
    logic                val;
    logic                rdy;
    logic                sop;
    logic                eop;
    logic                err;
    logic [MOD_BITS-1:0] mod;
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;

    modport master (output val, sop, eop, err, mod, dat, ctl, input  rdy);
    modport slave  (input  val, sop, eop, err, mod, dat, ctl, output rdy);
endinterface

// File: rtl/ec_fp_op_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ec_fp_op_arbiter_rr_arbiter
// Round-robin arbiter, reusable for any shared resource.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_req        : one request bit per requester
//   i_accept     : the resource can take a beat this cycle; when a request
//                  is also present the pointer moves past the winner
//   o_found      : at least one request is present
//   o_idx        : index of the winner
//   o_grant      : one-hot winner
// ---------------------------------------------------------------------------
module ec_fp_op_arbiter_rr_arbiter
    import ec_fp_op_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int IDX_BITS = clog2_min1(NUM_REQ)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic                i_accept,
    output logic                o_found,
    output logic [IDX_BITS-1:0] o_idx,
    output logic [NUM_REQ-1:0]  o_grant
);

    logic [PTR_BITS-1:0]    r_ptr;
    logic [MAX_CLIENTS-1:0] w_req_ext;
    rr_pick_t               w_pick;

    assign w_req_ext = MAX_CLIENTS'(i_req);
    assign w_pick    = rr_find_first(w_req_ext, int'(r_ptr), NUM_REQ);
    assign o_found   = w_pick.found;
    assign o_idx     = IDX_BITS'(w_pick.idx);

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
            assign o_grant[gi] = w_pick.found && (w_pick.idx == PTR_BITS'(gi));
        end
    endgenerate

    // The pointer only moves on an accepted beat, so an idle period never
    // shifts priority away from the client that is next in line.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_accept && w_pick.found) begin
            if (int'(w_pick.idx) == NUM_REQ - 1) r_ptr <= '0;
            else                                 r_ptr <= w_pick.idx + PTR_BITS'(1);
        end
    end

endmodule

// File: rtl/ec_fp_op_arbiter.sv
// ---------------------------------------------------------------------------
// ec_fp_op_arbiter
// Shares one Fp arithmetic unit between NUM_CLIENTS requesters. Requests are
// round-robin arbitrated into a single registered output stage, and the
// winning client index is stamped into the top TAG_BITS of ctl. Responses are
// routed back combinationally by that tag, with the tag field cleared.
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_req_if[N] slave : client requests, dat = {b, a} (2*DAT_BITS)
//   o_req_if master   : requests to the shared unit
//   i_res_if slave    : results from the shared unit (DAT_BITS)
//   o_res_if[N] master: per-client results
//   o_err             : sticky, a result arrived with an out-of-range tag
// ---------------------------------------------------------------------------
module ec_fp_op_arbiter
    import ec_fp_op_arbiter_pkg::*;
#(
    parameter int NUM_CLIENTS = 2,
    parameter int DAT_BITS    = 381,
    parameter int CTL_BITS    = 16,
    parameter int MOD_BITS    = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    ec_fp_op_arbiter_if.slave  i_req_if [NUM_CLIENTS],
    ec_fp_op_arbiter_if.master o_req_if,
    ec_fp_op_arbiter_if.slave  i_res_if,
    ec_fp_op_arbiter_if.master o_res_if [NUM_CLIENTS],
    output logic               o_err
);

    localparam int TAG_BITS = clog2_min1(NUM_CLIENTS);
    localparam int TAG_LSB  = CTL_BITS - TAG_BITS;
    localparam int REQ_BITS = 2 * DAT_BITS;

    // ---------------- request path ----------------
    logic [NUM_CLIENTS-1:0] w_cli_val;
    logic [NUM_CLIENTS-1:0] w_cli_err;
    logic [REQ_BITS-1:0]    w_cli_dat [NUM_CLIENTS];
    logic [CTL_BITS-1:0]    w_cli_ctl [NUM_CLIENTS];
    logic [NUM_CLIENTS-1:0] w_grant;
    logic [TAG_BITS-1:0]    w_idx;
    logic                   w_found;
    logic                   w_can_load;
    logic                   w_accept;
    logic [REQ_BITS-1:0]    w_sel_dat;
    logic [CTL_BITS-1:0]    w_sel_ctl;
    logic                   w_sel_err;
    logic [CTL_BITS-1:0]    w_load_ctl;

    logic                   r_val;
    logic [REQ_BITS-1:0]    r_dat;
    logic [CTL_BITS-1:0]    r_ctl;
    logic                   r_err;

    // The stage can take a new beat when empty or when its beat leaves now.
    assign w_can_load = !r_val || o_req_if.rdy;
    assign w_accept   = w_can_load && w_found;

    generate
        for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_req
            assign w_cli_val[gi]    = i_req_if[gi].val;
            assign w_cli_err[gi]    = i_req_if[gi].err;
            assign w_cli_dat[gi]    = i_req_if[gi].dat;
            assign w_cli_ctl[gi]    = i_req_if[gi].ctl;
            assign i_req_if[gi].rdy = w_can_load && w_grant[gi];
        end
    endgenerate

    ec_fp_op_arbiter_rr_arbiter #(
        .NUM_REQ  (NUM_CLIENTS),
        .IDX_BITS (TAG_BITS)
    ) u_rr (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_req    (w_cli_val),
        .i_accept (w_can_load),
        .o_found  (w_found),
        .o_idx    (w_idx),
        .o_grant  (w_grant)
    );

    // One-hot grant mux; no client selected leaves zeros (unused then).
    always_comb begin
        w_sel_dat = '0;
        w_sel_ctl = '0;
        w_sel_err = 1'b0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (w_grant[k]) begin
                w_sel_dat = w_cli_dat[k];
                w_sel_ctl = w_cli_ctl[k];
                w_sel_err = w_cli_err[k];
            end
        end
    end

    assign w_load_ctl = {w_idx, w_sel_ctl[TAG_LSB-1:0]};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_val <= 1'b0;
            r_dat <= '0;
            r_ctl <= '0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_val <= 1'b1;
            r_dat <= w_sel_dat;
            r_ctl <= w_load_ctl;
            r_err <= w_sel_err;
        end else if (o_req_if.rdy) begin
            r_val <= 1'b0;
        end
    end

    assign o_req_if.val = r_val;
    assign o_req_if.dat = r_dat;
    assign o_req_if.ctl = r_ctl;
    assign o_req_if.err = r_err;
    assign o_req_if.sop = 1'b1;
    assign o_req_if.eop = 1'b1;
    assign o_req_if.mod = '0;

    // ---------------- response path ----------------
    logic [TAG_BITS-1:0]    w_res_tag;
    logic                   w_tag_ok;
    logic [CTL_BITS-1:0]    w_res_ctl;
    logic [NUM_CLIENTS-1:0] w_cli_rdy;
    logic                   w_res_rdy;
    logic                   r_bad_tag;

    assign w_res_tag = i_res_ctl_tag(i_res_if.ctl);
    assign w_tag_ok  = ({1'b0, w_res_tag} < (TAG_BITS + 1)'(NUM_CLIENTS));
    assign w_res_ctl = {{TAG_BITS{1'b0}}, i_res_if.ctl[TAG_LSB-1:0]};

    function automatic logic [TAG_BITS-1:0] i_res_ctl_tag(input logic [CTL_BITS-1:0] ctl);
        return ctl[CTL_BITS-1 -: TAG_BITS];
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_res
            assign o_res_if[gi].val = i_res_if.val && (w_res_tag == TAG_BITS'(gi));
            assign o_res_if[gi].dat = i_res_if.dat;
            assign o_res_if[gi].ctl = w_res_ctl;
            assign o_res_if[gi].err = i_res_if.err;
            assign o_res_if[gi].mod = i_res_if.mod;
            assign o_res_if[gi].sop = i_res_if.sop;
            assign o_res_if[gi].eop = i_res_if.eop;
            assign w_cli_rdy[gi]    = o_res_if[gi].rdy;
        end
    endgenerate

    // An unknown tag has no owner to wait for, so the beat is swallowed.
    always_comb begin
        w_res_rdy = 1'b1;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (w_res_tag == TAG_BITS'(k)) w_res_rdy = w_cli_rdy[k];
        end
    end

    assign i_res_if.rdy = w_res_rdy;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bad_tag <= 1'b0;
        end else if (i_res_if.val && !w_tag_ok) begin
            r_bad_tag <= 1'b1;
        end
    end

    assign o_err = r_bad_tag;

endmodule
